fsm_share_arbiter: RTL

FSM_SHARE_ARBITER -- requirements
Module: fsm_share_arbiter

---
 rtl/fsm_share_arbiter_if.sv | 25 ++
 rtl/fsm_share_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fsm_share_arbiter_if.sv
// Handshake bundle between two requesters and the shared-machine arbiter.
// The master side drives both requesters' symbols; the slave side is the arbiter.
interface fsm_share_arbiter_if;
  logic       req0;
  logic       a0;
  logic       b0;
  logic       req1;
  logic       a1;
  logic       b1;
  logic [1:0] gnt;
  logic       vld;
  logic       id;
  logic       y_o;
  logic       z_o;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt, vld, id, y_o, z_o
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt, vld, id, y_o, z_o
  );
endinterface

// File: rtl/fsm_share_arbiter.sv
// Two-requester arbiter time-sharing one small Mealy machine, with burst-limited ownership.
// Define CTX_SAVE_EN to keep a private machine context per requester instead of one shared context.
module fsm_share_arbiter #(
  parameter int BURST = 4
) (
  input logic                clk,
  input logic                rst_n,
  fsm_share_arbiter_if.slave bus
);

  localparam logic [3:0] BURST_C = 4'(BURST);
`ifdef CTX_SAVE_EN
  localparam int NCTX = 2;
`else
  localparam int NCTX = 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic            last_reg, last_next;

  logic            grant_any;
  logic            grant_idx;
  logic            owner_idx;
  logic            owner_active;
  logic            other_req;
  logic [1:0]      gnt;

  logic [NCTX-1:0] ctx_q1;
  logic [NCTX-1:0] ctx_q2;
  logic            sym_a, sym_b;
  logic            cur_q1, cur_q2;
  logic            sel_s, sel_w;
  logic            y_val, z_val;
  logic            q1_new, q2_new;

  logic            vld_reg, id_reg, y_reg, z_reg;

  genvar gi;

  // ---------------- arbiter state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  // ---------------- next-state and grant decision ----------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    last_next    = last_reg;
    grant_any    = 1'b0;
    grant_idx    = 1'b0;
    owner_idx    = (state_reg == OWN1);
    owner_active = ((state_reg == OWN0) && bus.req0) || ((state_reg == OWN1) && bus.req1);
    other_req    = owner_idx ? bus.req0 : bus.req1;

    if (rst_n) begin
      if (owner_active) begin
        grant_any = 1'b1;
        if ((cnt_reg >= BURST_C) && other_req) begin
          // Hand over in the same cycle; cnt restarts at the handover grant.
          grant_idx  = ~owner_idx;
          state_next = owner_idx ? OWN0 : OWN1;
          cnt_next   = 4'd1;
        end else begin
          grant_idx = owner_idx;
          if (cnt_reg < BURST_C) begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
      end else if (bus.req0 || bus.req1) begin
        // Idle, or the owner let go: pick whoever is asking, tie goes away from last.
        grant_any  = 1'b1;
        grant_idx  = (bus.req0 && bus.req1) ? ~last_reg : bus.req1;
        state_next = grant_idx ? OWN1 : OWN0;
        cnt_next   = 4'd1;
      end else begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    end

    if (grant_any) begin
      last_next = grant_idx;
    end
  end

  // ---------------- outputs: grant and shared-machine evaluation ----------------
  always_comb begin
    gnt = 2'b00;
    if (grant_any) begin
      gnt = grant_idx ? 2'b10 : 2'b01;
    end

    sym_a = grant_idx ? bus.a1 : bus.a0;
    sym_b = grant_idx ? bus.b1 : bus.b0;
`ifdef CTX_SAVE_EN
    cur_q1 = ctx_q1[grant_idx];
    cur_q2 = ctx_q2[grant_idx];
`else
    cur_q1 = ctx_q1[0];
    cur_q2 = ctx_q2[0];
`endif

    sel_s  = sym_b & ~cur_q2;
    sel_w  = sym_a | sel_s;
    y_val  = cur_q1;
    z_val  = ~cur_q1 | sel_s;
    q1_new = sel_w;
    q2_new = ~sel_w & cur_q1;
  end

  assign bus.gnt = gnt;

  // ---------------- machine contexts ----------------
  for (gi = 0; gi < NCTX; gi++) begin : g_ctx
    logic q1_reg;
    logic q2_reg;
    logic upd;

`ifdef CTX_SAVE_EN
    assign upd = grant_any && (grant_idx == 1'(gi));
`else
    assign upd = grant_any;
`endif

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q1_reg <= 1'b0;
        q2_reg <= 1'b0;
      end else if (upd) begin
        q1_reg <= q1_new;
        q2_reg <= q2_new;
      end
    end

    assign ctx_q1[gi] = q1_reg;
    assign ctx_q2[gi] = q2_reg;
  end

  // ---------------- registered result ----------------
  // Without a grant only vld drops; id/y/z keep the last delivered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_reg <= 1'b0;
      id_reg  <= 1'b0;
      y_reg   <= 1'b0;
      z_reg   <= 1'b0;
    end else begin
      vld_reg <= grant_any;
      if (grant_any) begin
        id_reg <= grant_idx;
        y_reg  <= y_val;
        z_reg  <= z_val;
      end
    end
  end

  assign bus.vld = vld_reg;
  assign bus.id  = id_reg;
  assign bus.y_o = y_reg;
  assign bus.z_o = z_reg;

endmodule
